// File: rtl/type_rule_match.sv
// Three-stage header classifier: extracts TYPE_NUM 16-bit fields at programmable
// byte offsets, matches them against a masked rule table and reports the lowest hit.
module type_rule_match #(
   parameter int TYPE_OFFSET_WIDTH = 7,
   parameter int TYPE_NUM          = 4,
   parameter int RULE_NUM          = 4,
   parameter int RULE_WIDTH        = 129,
   parameter int HDR_BYTES         = 64,
   parameter int TAG_WIDTH         = 8,
   localparam int IDX_WIDTH        = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] i_type_offset,
   input  logic [RULE_NUM-1:0]                   i_typeRule_wren,
   input  logic [RULE_WIDTH-1:0]                 i_typeRule_wdata,
   input  logic                                  i_hdr_valid,
   input  logic [HDR_BYTES*8-1:0]                i_hdr_data,
   input  logic [TAG_WIDTH-1:0]                  i_hdr_tag,
   output logic                                  o_res_valid,
   output logic                                  o_res_hit,
   output logic [IDX_WIDTH-1:0]                  o_res_idx,
   output logic [TAG_WIDTH-1:0]                  o_res_tag,
   output logic [31:0]                           o_hit_cnt,
   output logic [31:0]                           o_miss_cnt
);

   logic [RULE_NUM-1:0]     entry_valid;
   logic [TYPE_NUM*32-1:0]  entry_km [RULE_NUM];

   logic                    s1_valid;
   logic [15:0]             s1_field [TYPE_NUM];
   logic [TAG_WIDTH-1:0]    s1_tag;
   logic [15:0]             hdr_field [TYPE_NUM];

   logic                    s2_valid;
   logic [RULE_NUM-1:0]     s2_hit;
   logic [TAG_WIDTH-1:0]    s2_tag;
   logic [RULE_NUM-1:0]     rule_hit;
   logic [IDX_WIDTH-1:0]    first_idx;

   // Byte 0 sits at the MSBs; anything past the window reads as zero.
   function automatic logic [7:0] get_byte(input logic [HDR_BYTES*8-1:0] data,
                                           input logic [TYPE_OFFSET_WIDTH:0] idx);
      logic [7:0] result;
      result = 8'h00;
      for (int k = 0; k < HDR_BYTES; k++) begin
         if (int'(idx) == k) result = data[(HDR_BYTES-1-k)*8 +: 8];
      end
      return result;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         entry_valid <= '0;
      end else begin
         for (int r = 0; r < RULE_NUM; r++) begin
            if (i_typeRule_wren[r]) entry_valid[r] <= i_typeRule_wdata[TYPE_NUM*32];
         end
      end
   end

   // Key/mask storage only matters once its valid bit is set, so it has no reset.
   always_ff @(posedge i_clk) begin
      for (int r = 0; r < RULE_NUM; r++) begin
         if (i_typeRule_wren[r]) entry_km[r] <= i_typeRule_wdata[TYPE_NUM*32-1:0];
      end
   end

   always_comb begin
      logic [TYPE_OFFSET_WIDTH:0] lo;
      lo = '0;
      for (int i = 0; i < TYPE_NUM; i++) begin
         lo = {1'b0, i_type_offset[i*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH]};
         hdr_field[i] = {get_byte(i_hdr_data, lo),
                         get_byte(i_hdr_data, lo + {{TYPE_OFFSET_WIDTH{1'b0}}, 1'b1})};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_tag   <= '0;
         for (int i = 0; i < TYPE_NUM; i++) s1_field[i] <= '0;
      end else begin
         s1_valid <= i_hdr_valid;
         if (i_hdr_valid) begin
            s1_tag <= i_hdr_tag;
            for (int i = 0; i < TYPE_NUM; i++) s1_field[i] <= hdr_field[i];
         end
      end
   end

   always_comb begin
      logic [15:0] key;
      logic [15:0] mask;
      key      = '0;
      mask     = '0;
      rule_hit = '0;
      for (int r = 0; r < RULE_NUM; r++) begin
         rule_hit[r] = entry_valid[r];
         for (int i = 0; i < TYPE_NUM; i++) begin
            key  = entry_km[r][i*32 +: 16];
            mask = entry_km[r][i*32+16 +: 16];
            if ((s1_field[i] & mask) != (key & mask)) rule_hit[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid <= 1'b0;
         s2_hit   <= '0;
         s2_tag   <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_hit <= rule_hit;
            s2_tag <= s1_tag;
         end
      end
   end

   always_comb begin
      first_idx = '0;
      for (int r = RULE_NUM-1; r >= 0; r--) begin
         if (s2_hit[r]) first_idx = IDX_WIDTH'(r);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_res_valid <= 1'b0;
         o_res_hit   <= 1'b0;
         o_res_idx   <= '0;
         o_res_tag   <= '0;
      end else begin
         o_res_valid <= s2_valid;
         if (s2_valid) begin
            o_res_hit <= |s2_hit;
            o_res_idx <= first_idx;
            o_res_tag <= s2_tag;
         end
      end
   end

   // Counters trail the result by one cycle and stick at all-ones.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_hit_cnt  <= '0;
         o_miss_cnt <= '0;
      end else if (o_res_valid) begin
         if (o_res_hit) begin
            if (o_hit_cnt != 32'hFFFF_FFFF) o_hit_cnt <= o_hit_cnt + 32'd1;
         end else begin
            if (o_miss_cnt != 32'hFFFF_FFFF) o_miss_cnt <= o_miss_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_type_rule_match.sv
// Directed bench for type_rule_match: table-driven lookups plus hand-built
// sequences for rule-update timing, out-of-window bytes, saturation and reset.
module tb_type_rule_match;

   localparam int TYPE_OFFSET_WIDTH = 7;
   localparam int TYPE_NUM          = 4;
   localparam int RULE_NUM          = 4;
   localparam int RULE_WIDTH        = 129;
   localparam int HDR_BYTES         = 64;
   localparam int TAG_WIDTH         = 8;

   typedef logic [HDR_BYTES*8-1:0] hdr_t;

   typedef struct {
      logic [7:0] b12;
      logic [7:0] b13;
      logic [7:0] b14;
      logic [7:0] b63;
      logic [7:0] tag;
      logic       want_hit;
      logic [1:0] want_idx;
   } vec_t;

   logic                                  i_clk;
   logic                                  i_rst_n;
   logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] i_type_offset;
   logic [RULE_NUM-1:0]                   i_typeRule_wren;
   logic [RULE_WIDTH-1:0]                 i_typeRule_wdata;
   logic                                  i_hdr_valid;
   logic [HDR_BYTES*8-1:0]                i_hdr_data;
   logic [TAG_WIDTH-1:0]                  i_hdr_tag;
   logic                                  o_res_valid;
   logic                                  o_res_hit;
   logic [1:0]                            o_res_idx;
   logic [TAG_WIDTH-1:0]                  o_res_tag;
   logic [31:0]                           o_hit_cnt;
   logic [31:0]                           o_miss_cnt;

   int          checks;
   int          failures;
   logic [31:0] exp_hit_cnt;
   logic [31:0] exp_miss_cnt;
   vec_t        vecs [6];

   type_rule_match #(
      .TYPE_OFFSET_WIDTH(TYPE_OFFSET_WIDTH),
      .TYPE_NUM(TYPE_NUM),
      .RULE_NUM(RULE_NUM),
      .RULE_WIDTH(RULE_WIDTH),
      .HDR_BYTES(HDR_BYTES),
      .TAG_WIDTH(TAG_WIDTH)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_type_offset(i_type_offset),
      .i_typeRule_wren(i_typeRule_wren),
      .i_typeRule_wdata(i_typeRule_wdata),
      .i_hdr_valid(i_hdr_valid),
      .i_hdr_data(i_hdr_data),
      .i_hdr_tag(i_hdr_tag),
      .o_res_valid(o_res_valid),
      .o_res_hit(o_res_hit),
      .o_res_idx(o_res_idx),
      .o_res_tag(o_res_tag),
      .o_hit_cnt(o_hit_cnt),
      .o_miss_cnt(o_miss_cnt)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Bytes not named explicitly carry a 0x5A filler so masking is actually exercised.
   function automatic hdr_t mk_hdr(input logic [7:0] b12, input logic [7:0] b13,
                                   input logic [7:0] b14, input logic [7:0] b63);
      hdr_t h;
      for (int k = 0; k < HDR_BYTES; k++) h[(HDR_BYTES-1-k)*8 +: 8] = 8'h5A;
      h[(HDR_BYTES-1-12)*8 +: 8] = b12;
      h[(HDR_BYTES-1-13)*8 +: 8] = b13;
      h[(HDR_BYTES-1-14)*8 +: 8] = b14;
      h[(HDR_BYTES-1-63)*8 +: 8] = b63;
      return h;
   endfunction

   function automatic logic [RULE_WIDTH-1:0] mk_rule(input logic vld,
                                                     input logic [15:0] k0, input logic [15:0] m0,
                                                     input logic [15:0] k1, input logic [15:0] m1);
      logic [RULE_WIDTH-1:0] r;
      r        = '0;
      r[128]   = vld;
      r[15:0]  = k0;
      r[31:16] = m0;
      r[47:32] = k1;
      r[63:48] = m1;
      return r;
   endfunction

   task automatic write_rule(input int idx, input logic [RULE_WIDTH-1:0] data);
      i_typeRule_wren       = '0;
      i_typeRule_wren[idx]  = 1'b1;
      i_typeRule_wdata      = data;
      @(negedge i_clk);
      i_typeRule_wren       = '0;
   endtask

   task automatic set_offset(input int idx, input logic [TYPE_OFFSET_WIDTH-1:0] off);
      i_type_offset[idx*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH] = off;
   endtask

   task automatic apply_stimulus(input hdr_t hdr, input logic [7:0] tag);
      i_hdr_valid = 1'b1;
      i_hdr_data  = hdr;
      i_hdr_tag   = tag;
      @(negedge i_clk);
      i_hdr_valid = 1'b0;
   endtask

   // One isolated beat: result three edges later, then hold and counter update.
   task automatic run_single(input string name, input hdr_t hdr, input logic [7:0] tag,
                             input logic want_hit, input logic [1:0] want_idx);
      apply_stimulus(hdr, tag);
      repeat (2) @(negedge i_clk);
      check_output({name, "_valid"}, 32'(o_res_valid), 32'd1);
      check_output({name, "_hit"}, 32'(o_res_hit), 32'(want_hit));
      check_output({name, "_idx"}, 32'(o_res_idx), 32'(want_idx));
      check_output({name, "_tag"}, 32'(o_res_tag), 32'(tag));
      if (want_hit) exp_hit_cnt = sat_inc(exp_hit_cnt);
      else exp_miss_cnt = sat_inc(exp_miss_cnt);
      @(negedge i_clk);
      check_output({name, "_valid_drop"}, 32'(o_res_valid), 32'd0);
      check_output({name, "_tag_hold"}, 32'(o_res_tag), 32'(tag));
      check_output({name, "_hit_cnt"}, o_hit_cnt, exp_hit_cnt);
      check_output({name, "_miss_cnt"}, o_miss_cnt, exp_miss_cnt);
   endtask

   initial begin
      logic seen_valid;
      checks           = 0;
      failures         = 0;
      exp_hit_cnt      = '0;
      exp_miss_cnt     = '0;
      i_rst_n          = 1'b0;
      i_type_offset    = '0;
      i_typeRule_wren  = '0;
      i_typeRule_wdata = '0;
      i_hdr_valid      = 1'b0;
      i_hdr_data       = '0;
      i_hdr_tag        = '0;

      vecs[0] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h31, 1'b1, 2'd2};
      vecs[1] = '{8'h86, 8'hDD, 8'h00, 8'h00, 8'h32, 1'b0, 2'd0};
      vecs[2] = '{8'h08, 8'h00, 8'h45, 8'h00, 8'h33, 1'b1, 2'd1};
      vecs[3] = '{8'h86, 8'hDD, 8'h45, 8'h00, 8'h34, 1'b1, 2'd1};
      vecs[4] = '{8'h86, 8'hDD, 8'h4F, 8'h00, 8'h35, 1'b1, 2'd3};
      vecs[5] = '{8'h08, 8'h01, 8'h00, 8'h00, 8'h36, 1'b0, 2'd0};

      set_offset(0, 7'd12);
      set_offset(1, 7'd14);
      set_offset(2, 7'd20);
      set_offset(3, 7'd40);

      repeat (2) @(negedge i_clk);
      check_output("rst_valid", 32'(o_res_valid), 32'd0);
      check_output("rst_hit", 32'(o_res_hit), 32'd0);
      check_output("rst_idx", 32'(o_res_idx), 32'd0);
      check_output("rst_tag", 32'(o_res_tag), 32'd0);
      check_output("rst_hit_cnt", o_hit_cnt, 32'd0);
      check_output("rst_miss_cnt", o_miss_cnt, 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      $display("[TB] empty table lookup");
      run_single("empty", mk_hdr(8'h08, 8'h00, 8'h00, 8'h00), 8'h11, 1'b0, 2'd0);

      write_rule(2, mk_rule(1'b1, 16'h0800, 16'hFFFF, 16'h0000, 16'h0000));
      write_rule(1, mk_rule(1'b1, 16'h0000, 16'h0000, 16'h4500, 16'hFF00));
      write_rule(3, mk_rule(1'b1, 16'h0000, 16'h0000, 16'h4000, 16'hF000));

      $display("[TB] table vectors");
      for (int i = 0; i < 6; i++) begin
         run_single($sformatf("vec%0d", i),
                    mk_hdr(vecs[i].b12, vecs[i].b13, vecs[i].b14, vecs[i].b63),
                    vecs[i].tag, vecs[i].want_hit, vecs[i].want_idx);
      end

      $display("[TB] field straddling the window end");
      set_offset(0, 7'd63);
      write_rule(0, mk_rule(1'b1, 16'hAB00, 16'hFFFF, 16'h0000, 16'h0000));
      run_single("edge_hit", mk_hdr(8'h00, 8'h00, 8'h00, 8'hAB), 8'h41, 1'b1, 2'd0);
      run_single("edge_miss", mk_hdr(8'h00, 8'h00, 8'h00, 8'hAC), 8'h42, 1'b0, 2'd0);

      $display("[TB] rule rewrite under back-to-back beats");
      set_offset(0, 7'd12);
      for (int i = 0; i < 8; i++) begin
         if (i >= 3 && i <= 6) begin
            check_output($sformatf("b2b%0d_valid", i-3), 32'(o_res_valid), 32'd1);
            check_output($sformatf("b2b%0d_hit", i-3), 32'(o_res_hit), 32'd1);
            check_output($sformatf("b2b%0d_idx", i-3), 32'(o_res_idx), (i-3 < 2) ? 32'd2 : 32'd0);
            check_output($sformatf("b2b%0d_tag", i-3), 32'(o_res_tag), 32'h21 + 32'(i-3));
            exp_hit_cnt = sat_inc(exp_hit_cnt);
         end
         if (i == 7) check_output("b2b_valid_end", 32'(o_res_valid), 32'd0);
         i_hdr_valid      = (i < 4);
         i_hdr_data       = mk_hdr(8'h08, 8'h00, 8'h00, 8'h00);
         i_hdr_tag        = 8'h21 + 8'(i);
         i_typeRule_wren  = (i == 2) ? 4'b0001 : 4'b0000;
         i_typeRule_wdata = mk_rule(1'b1, 16'h0800, 16'hFFFF, 16'h0000, 16'h0000);
         @(negedge i_clk);
      end
      check_output("b2b_hit_cnt", o_hit_cnt, exp_hit_cnt);
      check_output("b2b_miss_cnt", o_miss_cnt, exp_miss_cnt);

      $display("[TB] hit counter saturation");
      force dut.o_hit_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.o_hit_cnt;
      exp_hit_cnt = 32'hFFFF_FFFE;
      @(negedge i_clk);
      for (int i = 0; i < 2; i++) begin
         i_hdr_valid = 1'b1;
         i_hdr_data  = mk_hdr(8'h08, 8'h00, 8'h00, 8'h00);
         i_hdr_tag   = 8'h51 + 8'(i);
         @(negedge i_clk);
         exp_hit_cnt = sat_inc(exp_hit_cnt);
      end
      i_hdr_valid = 1'b0;
      repeat (4) @(negedge i_clk);
      check_output("sat_hit_cnt", o_hit_cnt, exp_hit_cnt);
      check_output("sat_miss_cnt", o_miss_cnt, exp_miss_cnt);

      $display("[TB] reset with beats in flight");
      for (int i = 0; i < 3; i++) begin
         i_hdr_valid = 1'b1;
         i_hdr_data  = mk_hdr(8'h08, 8'h00, 8'h00, 8'h00);
         i_hdr_tag   = 8'h61 + 8'(i);
         if (i < 2) @(negedge i_clk);
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      check_output("mid_rst_valid", 32'(o_res_valid), 32'd0);
      check_output("mid_rst_hit", 32'(o_res_hit), 32'd0);
      check_output("mid_rst_tag", 32'(o_res_tag), 32'd0);
      check_output("mid_rst_hit_cnt", o_hit_cnt, 32'd0);
      check_output("mid_rst_miss_cnt", o_miss_cnt, 32'd0);
      i_hdr_valid = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         if (o_res_valid) seen_valid = 1'b1;
      end
      check_output("post_rst_no_result", 32'(seen_valid), 32'd0);
      check_output("post_rst_hit_cnt", o_hit_cnt, 32'd0);
      check_output("post_rst_miss_cnt", o_miss_cnt, 32'd0);
      exp_hit_cnt  = '0;
      exp_miss_cnt = '0;
      run_single("post_rst_table", mk_hdr(8'h08, 8'h00, 8'h00, 8'h00), 8'h71, 1'b0, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
